muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide execution unit for the RV32M/RV64M extension. It sits beside the ALU in the execute stage and takes operands plus funct3 when the decoder flags an R-type op with funct7 = 7'b0000001. It computes over multiple cycles, with valid/ready handshakes on both sides and a kill input for pipeline flush.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per CALC cycle; legal values 1 or 2; XLEN divisible by it.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept; high only in IDLE.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
src_a  input  XLEN  rs1 operand (multiplicand / dividend).
src_b  input  XLEN  rs2 operand (multiplier / divisor).
kill  input  1  synchronous flush; abandons any operation.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  XLEN  result.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. On assertion: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all datapath registers 0. Takes effect immediately, including mid-operation; no pending result survives.
- Accept: a request is accepted on the rising edge where in_valid && in_ready. funct3 and operands are captured; later input changes are ignored.
- States and transitions:
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept of a special case.
  - CALC -> FIX after N = XLEN/BITS_PER_CYCLE iterations.
  - FIX -> DONE.
  - DONE -> IDLE when out_ready is high.
- Setup on accept:
  - Capture operand magnitudes and signs.
  - Signed operands: MULH a and b; MULHSU a only; DIV/REM a and b.
  - Negative signed operands are replaced by their two's-complement magnitude.
- CALC, multiply: shift-add on the 2*XLEN accumulator, BITS_PER_CYCLE multiplier bits per cycle.
- CALC, divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
- FIX: conditional negation.
  - Product (2*XLEN wide): negate if sign_a^sign_b.
  - Quotient: negate if sign_a^sign_b.
  - Remainder: takes the sign of the dividend.
- Result selection:
  - MUL: low XLEN of product.
  - MULH/MULHSU/MULHU: high XLEN of product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Latency: accept in cycle 0. out_valid first high in cycle N+2 (34 for XLEN=32, BPC=1; 18 with BPC=2).
- Special cases bypass CALC/FIX; out_valid is high in cycle 1:
  - Divisor zero: DIV/DIVU -> all ones; REM/REMU -> src_a.
  - Signed overflow (src_a = most-negative, src_b = all ones): DIV -> src_a; REM -> 0.
  - Multiply by zero is NOT a special case; it takes the normal latency.
- Output hold: in DONE, out_valid and result are held stable until out_ready. With out_ready already high in the first DONE cycle, the unit returns to IDLE next cycle. There is no back-to-back bypass, so in_ready rises one cycle after the result handshake.
- Kill:
  - Sampled every cycle.
  - When high: next state IDLE, out_valid low next cycle, result discarded.
  - Kill has priority over out_ready.
  - Kill in IDLE with in_valid high: the request is not accepted.
- out_valid is deasserted in all states except DONE. result is 0 outside DONE.
- Widths:
  - All arithmetic is modulo 2^XLEN, except the 2*XLEN product register.
  - Divider partial remainder register is XLEN+1 bits.
  - No X propagation from unused funct3 paths.

Test Plan:
1. MUL src_a=7, src_b=0xFFFFFFFD (XLEN=32, BPC=1) -> result 0xFFFFFFEB; out_valid first high exactly 34 cycles after accept; in_ready low throughout.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. Special cases each valid in cycle 1:
   - DIVU 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
   - REM same operands -> 0.
5. Backpressure and kill:
   - Hold out_ready low 5 cycles in DONE -> result stable, out_valid held, in_ready low; return to IDLE one cycle after out_ready.
   - Assert kill in CALC cycle 10 -> IDLE next cycle, no out_valid pulse.
6. Reset mid-operation: drop rst_n in CALC asynchronously between edges -> outputs reset immediately. Repeat tests 1-4 with XLEN=64 and BPC=2: 64-bit results correct, latency 34.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// master: issues operands, kill and out_ready; slave: the unit, returns in_ready/out_valid/result/busy.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, funct3, src_a, src_b, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct3, src_a, src_b, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Latency: XLEN/BITS_PER_CYCLE + 2 cycles from accept to out_valid; divide-by-zero/overflow in 1 cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; kill flushes to IDLE.
// Ports: clk, rst_n (async active-low), bus (slave side of muldiv_unit_if).
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_unit_if.slave bus
);
    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_op;
    logic              r_sign_a;
    logic              r_neg;
    logic [2*XLEN-1:0] r_acc;     // mul: {partial product, multiplier}; div: low half = dividend/quotient
    logic [XLEN:0]     r_rem;     // divider partial remainder
    logic [XLEN-1:0]   r_opnd;    // multiplicand or divisor magnitude
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept, w_is_div, w_sa, w_sb, w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special_res;
    logic [2*XLEN-1:0] w_acc_step;
    logic [XLEN:0]     w_rem_step, w_sum, w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot, w_remv, w_fix_res;

    // Request decode, only meaningful in the accept cycle.
    always_comb begin
        w_accept   = bus.in_valid && (r_state == S_IDLE) && !bus.kill;
        w_is_div   = bus.funct3[2];
        w_sa       = (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                      bus.funct3 == 3'b100 || bus.funct3 == 3'b110) && bus.src_a[XLEN-1];
        w_sb       = (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
                      bus.funct3 == 3'b110) && bus.src_b[XLEN-1];
        w_a_mag    = w_sa ? -bus.src_a : bus.src_a;
        w_b_mag    = w_sb ? -bus.src_b : bus.src_b;
        w_div_zero = w_is_div && (bus.src_b == '0);
        w_ovf      = w_is_div && !bus.funct3[0] &&
                     (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.src_b);
        w_special  = w_div_zero || w_ovf;
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = bus.funct3[1] ? bus.src_a : '1;
        else if (w_ovf)
            w_special_res = bus.funct3[1] ? '0 : bus.src_a;
    end

    // One CALC cycle: BITS_PER_CYCLE shift-add or restoring-divide steps chained combinationally.
    always_comb begin
        w_acc_step = r_acc;
        w_rem_step = r_rem;
        w_sum      = '0;
        w_diff     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (!r_op[2]) begin
                w_sum      = {1'b0, w_acc_step[2*XLEN-1:XLEN]} + (w_acc_step[0] ? {1'b0, r_opnd} : '0);
                w_acc_step = {w_sum, w_acc_step[XLEN-1:1]};
            end else begin
                w_rem_step             = {w_rem_step[XLEN-1:0], w_acc_step[XLEN-1]};
                w_acc_step[XLEN-1:0]   = {w_acc_step[XLEN-2:0], 1'b0};
                w_diff                 = w_rem_step - {1'b0, r_opnd};
                // MSB clear means the trial subtraction did not go negative.
                if (!w_diff[XLEN]) begin
                    w_rem_step    = w_diff;
                    w_acc_step[0] = 1'b1;
                end
            end
        end
    end

    // Sign fix-up and result selection.
    always_comb begin
        w_prod = r_neg ? -r_acc : r_acc;
        w_quot = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_remv = r_sign_a ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        case (r_op)
            3'b000:                  w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:          w_fix_res = w_quot;
            default:                 w_fix_res = w_remv;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CNT_W'(N-1)) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.kill) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op     <= bus.funct3;
                    r_sign_a <= w_sa;
                    r_neg    <= w_sa ^ w_sb;
                    r_cnt    <= '0;
                    r_rem    <= '0;
                    r_result <= w_special_res;
                    r_acc    <= {{XLEN{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
                    r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.result    = (r_state == S_DONE) ? r_result : '0;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) if32();
    muldiv_unit_if #(.XLEN(64)) if64();

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
    muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(2)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64.slave));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request, wait (bounded) for the result, then complete the handshake.
    task automatic run_op(input bit wide, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output bit rdy_low, output logic rdy_after);
        logic ov;
        @(posedge clk); #1;
        if (wide) begin
            if64.in_valid = 1'b1; if64.funct3 = f; if64.src_a = a; if64.src_b = b;
        end else begin
            if32.in_valid = 1'b1; if32.funct3 = f; if32.src_a = a[31:0]; if32.src_b = b[31:0];
        end
        @(posedge clk); #1;
        // Scramble the operands after accept: the unit must have captured them.
        if (wide) begin
            if64.in_valid = 1'b0; if64.src_a = ~a; if64.src_b = ~b; if64.funct3 = ~f;
        end else begin
            if32.in_valid = 1'b0; if32.src_a = ~a[31:0]; if32.src_b = ~b[31:0]; if32.funct3 = ~f;
        end
        lat = 1;
        rdy_low = 1'b1;
        ov = wide ? if64.out_valid : if32.out_valid;
        while (!ov && lat < 100) begin
            if ((wide ? if64.in_ready : if32.in_ready) !== 1'b0) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
            ov = wide ? if64.out_valid : if32.out_valid;
        end
        if ((wide ? if64.in_ready : if32.in_ready) !== 1'b0) rdy_low = 1'b0;
        res = wide ? if64.result : {32'h0, if32.result};
        if (wide) if64.out_ready = 1'b1; else if32.out_ready = 1'b1;
        @(posedge clk); #1;
        if (wide) if64.out_ready = 1'b0; else if32.out_ready = 1'b0;
        rdy_after = wide ? if64.in_ready : if32.in_ready;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset32_in_ready got %b want 1", if32.in_ready); end
        n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset32_out_valid got %b want 0", if32.out_valid); end
        n_cmp++; if (if32.busy !== 1'b0) begin n_fail++; $display("FAIL reset32_busy got %b want 0", if32.busy); end
        n_cmp++; if (if32.result !== 32'h0) begin n_fail++; $display("FAIL reset32_result got %h want 0", if32.result); end
        n_cmp++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset64_in_ready got %b want 1", if64.in_ready); end
        n_cmp++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset64_out_valid got %b want 0", if64.out_valid); end
        n_cmp++; if (if64.busy !== 1'b0) begin n_fail++; $display("FAIL reset64_busy got %b want 0", if64.busy); end
        n_cmp++; if (if64.result !== 64'h0) begin n_fail++; $display("FAIL reset64_result got %h want 0", if64.result); end
    endtask

    task automatic test_mul(input bit wide);
        logic [63:0] ones, r;
        int lat;
        bit rl;
        logic ra;
        ones = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        run_op(wide, 3'b000, 64'd7, ones - 64'd2, r, lat, rl, ra);
        n_cmp++; if (r !== ones - 64'd20) begin n_fail++; $display("FAIL mul_result w%0d got %h want %h", wide, r, ones - 64'd20); end
        n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency w%0d got %0d want 34", wide, lat); end
        n_cmp++; if (rl !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_low w%0d got %b want 1", wide, rl); end
        n_cmp++; if (ra !== 1'b1) begin n_fail++; $display("FAIL mul_in_ready_after w%0d got %b want 1", wide, ra); end
    endtask

    task automatic test_mulh(input bit wide);
        logic [63:0] ones, msb, quarter, r;
        logic [2:0]  fs [3];
        logic [63:0] as [3];
        logic [63:0] bs [3];
        logic [63:0] ex [3];
        int lat;
        bit rl;
        logic ra;
        ones    = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        msb     = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        quarter = wide ? 64'h4000_0000_0000_0000 : 64'h0000_0000_4000_0000;
        fs[0] = 3'b001; as[0] = msb;  bs[0] = msb;  ex[0] = quarter;
        fs[1] = 3'b011; as[1] = msb;  bs[1] = msb;  ex[1] = quarter;
        fs[2] = 3'b010; as[2] = ones; bs[2] = ones; ex[2] = ones;
        for (int i = 0; i < 3; i++) begin
            run_op(wide, fs[i], as[i], bs[i], r, lat, rl, ra);
            n_cmp++; if (r !== ex[i]) begin n_fail++; $display("FAIL mulh_result w%0d f%b got %h want %h", wide, fs[i], r, ex[i]); end
        end
    endtask

    task automatic test_div(input bit wide);
        logic [63:0] ones, r;
        logic [2:0]  fs [4];
        logic [63:0] as [4];
        logic [63:0] bs [4];
        logic [63:0] ex [4];
        int lat;
        bit rl;
        logic ra;
        ones = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        fs[0] = 3'b100; as[0] = ones - 64'd6; bs[0] = 64'd2; ex[0] = ones - 64'd2;
        fs[1] = 3'b110; as[1] = ones - 64'd6; bs[1] = 64'd2; ex[1] = ones;
        fs[2] = 3'b101; as[2] = 64'd100;      bs[2] = 64'd7; ex[2] = 64'd14;
        fs[3] = 3'b111; as[3] = 64'd100;      bs[3] = 64'd7; ex[3] = 64'd2;
        for (int i = 0; i < 4; i++) begin
            run_op(wide, fs[i], as[i], bs[i], r, lat, rl, ra);
            n_cmp++; if (r !== ex[i]) begin n_fail++; $display("FAIL div_result w%0d f%b got %h want %h", wide, fs[i], r, ex[i]); end
            n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL div_latency w%0d f%b got %0d want 34", wide, fs[i], lat); end
        end
    endtask

    task automatic test_special(input bit wide);
        logic [63:0] ones, msb, r;
        logic [2:0]  fs [4];
        logic [63:0] as [4];
        logic [63:0] bs [4];
        logic [63:0] ex [4];
        int lat;
        bit rl;
        logic ra;
        ones = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        msb  = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        fs[0] = 3'b101; as[0] = 64'd5; bs[0] = 64'd0; ex[0] = ones;
        fs[1] = 3'b110; as[1] = 64'd5; bs[1] = 64'd0; ex[1] = 64'd5;
        fs[2] = 3'b100; as[2] = msb;   bs[2] = ones;  ex[2] = msb;
        fs[3] = 3'b110; as[3] = msb;   bs[3] = ones;  ex[3] = 64'd0;
        for (int i = 0; i < 4; i++) begin
            run_op(wide, fs[i], as[i], bs[i], r, lat, rl, ra);
            n_cmp++; if (r !== ex[i]) begin n_fail++; $display("FAIL special_result w%0d f%b got %h want %h", wide, fs[i], r, ex[i]); end
            n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL special_latency w%0d f%b got %0d want 1", wide, fs[i], lat); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.funct3 = 3'b101; if32.src_a = 32'd100; if32.src_b = 32'd7;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        lat = 1;
        while (!if32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (if32.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done got %b want 1", if32.out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (if32.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc%0d got %b want 1", i, if32.out_valid); end
            n_cmp++; if (if32.result !== 32'd14) begin n_fail++; $display("FAIL bp_hold_result cyc%0d got %h want 0000000e", i, if32.result); end
            n_cmp++; if (if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, if32.in_ready); end
        end
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        if32.out_ready = 1'b0;
        n_cmp++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", if32.in_ready); end
        n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid got %b want 0", if32.out_valid); end
        n_cmp++; if (if32.result !== 32'd0) begin n_fail++; $display("FAIL bp_release_result got %h want 0", if32.result); end
    endtask

    task automatic test_kill();
        bit seen;
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.funct3 = 3'b000; if32.src_a = 32'd7; if32.src_b = 32'd3;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        n_cmp++; if (if32.busy !== 1'b1) begin n_fail++; $display("FAIL kill_busy_before got %b want 1", if32.busy); end
        if32.kill = 1'b1;
        @(posedge clk); #1;
        if32.kill = 1'b0;
        n_cmp++; if (if32.busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy_after got %b want 0", if32.busy); end
        n_cmp++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL kill_in_ready got %b want 1", if32.in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if32.out_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL kill_no_out_valid got %b want 0", seen); end
        // Kill in IDLE blocks acceptance of a concurrent request.
        if32.in_valid = 1'b1; if32.kill = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0; if32.kill = 1'b0;
        n_cmp++; if (if32.busy !== 1'b0) begin n_fail++; $display("FAIL kill_idle_accept got busy %b want 0", if32.busy); end
    endtask

    task automatic test_async_reset();
        bit seen;
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.funct3 = 3'b100; if32.src_a = 32'd1000; if32.src_b = 32'd3;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (if32.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got %b want 0", if32.busy); end
        n_cmp++; if (if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got %b want 1", if32.in_ready); end
        n_cmp++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid got %b want 0", if32.out_valid); end
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (if32.out_valid !== 1'b0 || if32.busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL areset_no_pending got %b want 0", seen); end
    endtask

    initial begin
        if32.in_valid = 1'b0; if32.funct3 = 3'b000; if32.src_a = '0; if32.src_b = '0; if32.kill = 1'b0; if32.out_ready = 1'b0;
        if64.in_valid = 1'b0; if64.funct3 = 3'b000; if64.src_a = '0; if64.src_b = '0; if64.kill = 1'b0; if64.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        #3 rst_n = 1'b1;
        test_mul(1'b0);
        test_mulh(1'b0);
        test_div(1'b0);
        test_special(1'b0);
        test_backpressure();
        test_kill();
        test_async_reset();
        test_mul(1'b1);
        test_mulh(1'b1);
        test_div(1'b1);
        test_special(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
